// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// Optional feature macro used by this slice: WB_BYPASS_EN.
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef GP_REG_COUNT
`define GP_REG_COUNT 32
`endif

package wb_pkg;
  localparam int unsigned WB_DATA_W    = `RISCV_WORD_WIDTH;
  localparam int unsigned WB_REG_COUNT = `GP_REG_COUNT;
  localparam int unsigned WB_ADDR_W    = $clog2(WB_REG_COUNT);

  typedef logic [WB_ADDR_W-1:0] reg_addr_t;
  typedef logic [WB_DATA_W-1:0] word_t;

  // Writeback source identity; also the round-robin pointer encoding.
  typedef enum logic {SRC_EXEC = 1'b0, SRC_LOAD = 1'b1} src_id_e;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback handshake bundle: two source request channels plus the
// register file write port driven by the arbiter.
interface wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              src0_valid_i;
  logic              src0_ready_o;
  logic [ADDR_W-1:0] src0_addr_i;
  logic [DATA_W-1:0] src0_data_i;
  logic              src1_valid_i;
  logic              src1_ready_o;
  logic [ADDR_W-1:0] src1_addr_i;
  logic [DATA_W-1:0] src1_data_i;
  logic              write_en_o;
  logic [ADDR_W-1:0] write_addr_o;
  logic [DATA_W-1:0] write_data_o;

  // Pipeline side: sources issue requests, register file consumes writes.
  modport master (
    output src0_valid_i, src0_addr_i, src0_data_i,
    output src1_valid_i, src1_addr_i, src1_data_i,
    input  src0_ready_o, src1_ready_o,
    input  write_en_o, write_addr_o, write_data_o
  );

  // Arbiter side.
  modport slave (
    input  src0_valid_i, src0_addr_i, src0_data_i,
    input  src1_valid_i, src1_addr_i, src1_data_i,
    output src0_ready_o, src1_ready_o,
    output write_en_o, write_addr_o, write_data_o
  );
endinterface

// File: rtl/wb_arbiter_reg_scoreboard.sv
// Per-register pending scoreboard with two combinational busy lookups.
// With WB_BYPASS_EN defined the in-flight write is forwarded elsewhere,
// so busy covers only pending producers.
module reg_scoreboard #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
`ifndef WB_BYPASS_EN
  input  logic              inflight_en,
  input  logic [ADDR_W-1:0] inflight_addr,
`endif
  input  logic [ADDR_W-1:0] read_addr_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic              busy_1,
  output logic              busy_2
);
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_nxt;

  // Next pending vector: clear first, then set, so a newer producer wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en)
      pending_nxt[clr_addr] = 1'b0;
    if (alloc_en && alloc_addr != '0)
      pending_nxt[alloc_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending register; flush drops every outstanding producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else if (flush)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  // Operand busy lookups; x0 is never busy.
  always_comb begin
    busy_1 = 1'b0;
    busy_2 = 1'b0;
    if (read_addr_1 != '0) begin
      busy_1 = pending[read_addr_1];
`ifndef WB_BYPASS_EN
      if (inflight_en && inflight_addr == read_addr_1)
        busy_1 = 1'b1;
`endif
    end
    if (read_addr_2 != '0) begin
      busy_2 = pending[read_addr_2];
`ifndef WB_BYPASS_EN
      if (inflight_en && inflight_addr == read_addr_2)
        busy_2 = 1'b1;
`endif
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between execute and load/CSR writeback,
// registered register-file write stage, and RAW scoreboard for decode.
// Optional macro WB_BYPASS_EN adds forwarding of the in-flight write.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W    = WB_DATA_W,
  parameter int unsigned REG_COUNT = WB_REG_COUNT,
  parameter int unsigned ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  wb_arbiter_if.slave       bus,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] read_addr_1_i,
  input  logic [ADDR_W-1:0] read_addr_2_i,
  output logic              busy_1_o,
  output logic              busy_2_o
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_1_o,
  output logic              fwd_2_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);
  src_id_e           rr_ptr;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;

  // Grant selection: lone requester wins, contention goes to rr_ptr, flush blocks all.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush_i) begin
      if (bus.src0_valid_i && bus.src1_valid_i) begin
        grant0 = (rr_ptr == SRC_EXEC);
        grant1 = (rr_ptr == SRC_LOAD);
      end else begin
        grant0 = bus.src0_valid_i;
        grant1 = bus.src1_valid_i;
      end
    end
  end

  // Data path mux for the granted source.
  always_comb begin
    grant_addr = bus.src0_addr_i;
    grant_data = bus.src0_data_i;
    if (grant1) begin
      grant_addr = bus.src1_addr_i;
      grant_data = bus.src1_data_i;
    end
  end

  assign bus.src0_ready_o = grant0;
  assign bus.src1_ready_o = grant1;

  // Registered write stage and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      rr_ptr <= SRC_EXEC;
    end else begin
      if (grant0 || grant1) begin
        we_q <= (grant_addr != ADDR_W'(REG_ZERO));
        wa_q <= grant_addr;
        wd_q <= grant_data;
      end else begin
        we_q <= 1'b0;
      end
      if (grant0 && bus.src1_valid_i)
        rr_ptr <= SRC_LOAD;
      else if (grant1 && bus.src0_valid_i)
        rr_ptr <= SRC_EXEC;
    end
  end

  assign bus.write_en_o   = we_q;
  assign bus.write_addr_o = wa_q;
  assign bus.write_data_o = wd_q;

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .alloc_en      (alloc_i),
    .alloc_addr    (alloc_addr_i),
    .clr_en        (grant0 || grant1),
    .clr_addr      (grant_addr),
    .flush         (flush_i),
`ifndef WB_BYPASS_EN
    .inflight_en   (we_q),
    .inflight_addr (wa_q),
`endif
    .read_addr_1   (read_addr_1_i),
    .read_addr_2   (read_addr_2_i),
    .busy_1        (busy_1_o),
    .busy_2        (busy_2_o)
  );

`ifdef WB_BYPASS_EN
  assign fwd_1_o    = we_q && (wa_q == read_addr_1_i);
  assign fwd_2_o    = we_q && (wa_q == read_addr_2_i);
  assign fwd_data_o = wd_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// corner sequences, then constrained-random traffic against a reference model.
module tb_wb_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RC = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          alloc_i;
  logic [AW-1:0] alloc_addr_i;
  logic          flush_i;
  logic [AW-1:0] read_addr_1_i;
  logic [AW-1:0] read_addr_2_i;
  logic          busy_1_o;
  logic          busy_2_o;
`ifdef WB_BYPASS_EN
  logic          fwd_1_o;
  logic          fwd_2_o;
  logic [DW-1:0] fwd_data_o;
`endif

  wb_arbiter #(.DATA_W(DW), .REG_COUNT(RC), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alloc_i       (alloc_i),
    .alloc_addr_i  (alloc_addr_i),
    .flush_i       (flush_i),
    .read_addr_1_i (read_addr_1_i),
    .read_addr_2_i (read_addr_2_i),
    .busy_1_o      (busy_1_o),
    .busy_2_o      (busy_2_o)
`ifdef WB_BYPASS_EN
    ,
    .fwd_1_o       (fwd_1_o),
    .fwd_2_o       (fwd_2_o),
    .fwd_data_o    (fwd_data_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: who gets the next tie, which registers await a
  // producer, and what the register file is being written with this cycle.
  bit          m_prefer_load;
  bit          m_pend[RC];
  bit          m_we;
  int          m_wa;
  logic [31:0] m_wd;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prefer_load = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_we = 1'b0;
    m_wa = 0;
    m_wd = '0;
  endtask

  // Which source wins this cycle: -1 none, 0 exec, 1 load.
  function automatic int model_pick();
    if (flush_i) return -1;
    if (bus.src0_valid_i && bus.src1_valid_i) return m_prefer_load ? 1 : 0;
    if (bus.src0_valid_i) return 0;
    if (bus.src1_valid_i) return 1;
    return -1;
  endfunction

  function automatic bit model_busy(int a);
    if (a == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    return m_pend[a];
`else
    return m_pend[a] || (m_we && m_wa == a);
`endif
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at the edge.
  task automatic tick();
    int g, a, ala;
    logic [31:0] d;
    bit both, al, fl;
    g    = model_pick();
    both = bus.src0_valid_i && bus.src1_valid_i;
    a    = (g == 1) ? int'(bus.src1_addr_i) : int'(bus.src0_addr_i);
    d    = (g == 1) ? bus.src1_data_i : bus.src0_data_i;
    al   = alloc_i;
    ala  = int'(alloc_addr_i);
    fl   = flush_i;
    @(posedge clk);
    if (g >= 0) begin
      m_we = (a != 0);
      m_wa = a;
      m_wd = d;
      if (both) m_prefer_load = (g == 0);
    end else begin
      m_we = 1'b0;
    end
    if (fl) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (g >= 0) m_pend[a] = 1'b0;
      if (al && ala != 0) m_pend[ala] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    bus.src0_valid_i = 1'b0;
    bus.src0_addr_i  = '0;
    bus.src0_data_i  = '0;
    bus.src1_valid_i = 1'b0;
    bus.src1_addr_i  = '0;
    bus.src1_data_i  = '0;
    alloc_i          = 1'b0;
    alloc_addr_i     = '0;
    flush_i          = 1'b0;
  endtask

  task automatic drv(int s, int v, int a, logic [31:0] d);
    if (s == 0) begin
      bus.src0_valid_i = (v != 0);
      bus.src0_addr_i  = AW'(a);
      bus.src0_data_i  = d;
    end else begin
      bus.src1_valid_i = (v != 0);
      bus.src1_addr_i  = AW'(a);
      bus.src1_data_i  = d;
    end
  endtask

  task automatic chk_wport(string tag, int we, int wa, logic [31:0] wd);
    chk({tag, " write_en"},   32'(bus.write_en_o),   32'(we));
    chk({tag, " write_addr"}, 32'(bus.write_addr_o), 32'(wa));
    chk({tag, " write_data"}, bus.write_data_o,      wd);
  endtask

  typedef struct {
    int v0, v1, a0, a1;
    logic [31:0] d0, d1;
    int fl;
    int r0, r1, we, wa;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mkv(int v0, int v1, int a0, int a1, logic [31:0] d0, logic [31:0] d1,
                               int fl, int r0, int r1, int we, int wa, logic [31:0] wd);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1; t.fl = fl;
    t.r0 = r0; t.r1 = r1; t.we = we; t.wa = wa; t.wd = wd;
    return t;
  endfunction

  initial begin
    bit hold0, hold1;
    int g;

    // Directed table starting from reset (tie pointer favours exec).
    //             v0 v1 a0  a1  d0            d1         fl r0 r1 we wa  wd
    tbl[0]  = mkv(1, 0,  5,  0, 32'hDEADBEEF, 32'h0,     0, 1, 0, 1,  5, 32'hDEADBEEF);
    tbl[1]  = mkv(0, 0,  0,  0, 32'h0,        32'h0,     0, 0, 0, 0,  5, 32'hDEADBEEF);
    tbl[2]  = mkv(1, 1,  3,  4, 32'h33,       32'h44,    0, 1, 0, 1,  3, 32'h33);
    tbl[3]  = mkv(1, 1,  3,  4, 32'h35,       32'h44,    0, 0, 1, 1,  4, 32'h44);
    tbl[4]  = mkv(1, 1,  6,  7, 32'h66,       32'h77,    0, 1, 0, 1,  6, 32'h66);
    tbl[5]  = mkv(0, 1,  0,  7, 32'h0,        32'h77,    0, 0, 1, 1,  7, 32'h77);
    tbl[6]  = mkv(1, 1,  8,  9, 32'h88,       32'h99,    0, 0, 1, 1,  9, 32'h99);
    tbl[7]  = mkv(1, 1,  8, 10, 32'h88,       32'h1010,  0, 1, 0, 1,  8, 32'h88);
    tbl[8]  = mkv(1, 1,  0, 10, 32'h1234,     32'h1010,  0, 0, 1, 1, 10, 32'h1010);
    tbl[9]  = mkv(1, 0,  0,  0, 32'h1234,     32'h0,     0, 1, 0, 0,  0, 32'h1234);
    tbl[10] = mkv(1, 0, 12,  0, 32'h12,       32'h0,     1, 0, 0, 0,  0, 32'h1234);
    tbl[11] = mkv(1, 0, 12,  0, 32'h12,       32'h0,     0, 1, 0, 1, 12, 32'h12);

    rst = 1'b1;
    idle();
    read_addr_1_i = '0;
    read_addr_2_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_wport("reset", 0, 0, 32'h0);
    rst = 1'b0;
    #2;
    chk("reset busy_1", 32'(busy_1_o), 32'h0);

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      drv(0, tbl[i].v0, tbl[i].a0, tbl[i].d0);
      drv(1, tbl[i].v1, tbl[i].a1, tbl[i].d1);
      flush_i = (tbl[i].fl != 0);
      #2;
      chk($sformatf("tbl%0d src0_ready", i), 32'(bus.src0_ready_o), 32'(tbl[i].r0));
      chk($sformatf("tbl%0d src1_ready", i), 32'(bus.src1_ready_o), 32'(tbl[i].r1));
      tick();
      chk_wport($sformatf("tbl%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd);
    end

    // Scoreboard: alloc x7, then load writes x7.
    idle();
    alloc_i = 1'b1; alloc_addr_i = 5'd7; read_addr_1_i = 5'd7;
    tick();
    alloc_i = 1'b0;
    drv(1, 1, 7, 32'hAA);
    #2;
    chk("alloc7 busy_1 pending", 32'(busy_1_o), 32'h1);
    chk("alloc7 src1_ready", 32'(bus.src1_ready_o), 32'h1);
    tick();
    idle();
    #2;
`ifdef WB_BYPASS_EN
    chk("alloc7 busy_1 inflight", 32'(busy_1_o), 32'h0);
    chk("alloc7 fwd_1", 32'(fwd_1_o), 32'h1);
    chk("alloc7 fwd_data", fwd_data_o, 32'hAA);
`else
    chk("alloc7 busy_1 inflight", 32'(busy_1_o), 32'h1);
`endif
    tick();
    #2;
    chk("alloc7 busy_1 done", 32'(busy_1_o), 32'h0);

    // Same-edge alloc and clear of x9: newer producer keeps it pending.
    drv(0, 1, 9, 32'h99);
    alloc_i = 1'b1; alloc_addr_i = 5'd9; read_addr_2_i = 5'd9;
    tick();
    idle();
    tick();
    #2;
    chk("same-edge x9 busy_2", 32'(busy_2_o), 32'h1);

    // x0 writes handshake but never enable; alloc of x0 is ignored.
    drv(0, 1, 0, 32'h1234);
    read_addr_1_i = 5'd0;
    #2;
    chk("x0 src0_ready", 32'(bus.src0_ready_o), 32'h1);
    tick();
    idle();
    chk("x0 write_en", 32'(bus.write_en_o), 32'h0);
    alloc_i = 1'b1; alloc_addr_i = 5'd0;
    tick();
    alloc_i = 1'b0;
    #2;
    chk("x0 busy_1", 32'(busy_1_o), 32'h0);

    // Flush then asynchronous reset.
    alloc_i = 1'b1; alloc_addr_i = 5'd10;
    tick();
    alloc_addr_i = 5'd11;
    tick();
    idle();
    drv(1, 1, 13, 32'h13);
    tick();
    idle();
    flush_i = 1'b1;
    alloc_i = 1'b1; alloc_addr_i = 5'd20;
    drv(0, 1, 12, 32'h12);
    read_addr_1_i = 5'd10; read_addr_2_i = 5'd11;
    #2;
    chk("flush src0_ready", 32'(bus.src0_ready_o), 32'h0);
    chk("flush src1_ready", 32'(bus.src1_ready_o), 32'h0);
    chk("flush busy_1 before", 32'(busy_1_o), 32'h1);
    chk_wport("flush inflight", 1, 13, 32'h13);
    tick();
    flush_i = 1'b0;
    alloc_i = 1'b0;
    #2;
    chk("flush busy_1 after", 32'(busy_1_o), 32'h0);
    chk("flush busy_2 after", 32'(busy_2_o), 32'h0);
    read_addr_1_i = 5'd20;
    #1;
    chk("flush alloc ignored", 32'(busy_1_o), 32'h0);
    alloc_i = 1'b1; alloc_addr_i = 5'd14;
    tick();
    idle();
    read_addr_1_i = 5'd14; read_addr_2_i = 5'd12;
    #2;
    chk("pre-reset busy_1", 32'(busy_1_o), 32'h1);
    chk_wport("pre-reset", 1, 12, 32'h12);
    rst = 1'b1;
    #1;
    chk_wport("async reset", 0, 0, 32'h0);
    chk("async reset busy_1", 32'(busy_1_o), 32'h0);
    chk("async reset busy_2", 32'(busy_2_o), 32'h0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    hold0 = 1'b0;
    hold1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) drv(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
      if (!hold1) drv(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
      alloc_i       = ($urandom_range(0, 2) == 0);
      alloc_addr_i  = AW'($urandom_range(0, 15));
      flush_i       = ($urandom_range(0, 15) == 0);
      read_addr_1_i = AW'($urandom_range(0, 15));
      read_addr_2_i = AW'($urandom_range(0, 15));
      #2;
      g = model_pick();
      chk("rand src0_ready", 32'(bus.src0_ready_o), 32'(g == 0));
      chk("rand src1_ready", 32'(bus.src1_ready_o), 32'(g == 1));
      chk("rand busy_1", 32'(busy_1_o), 32'(model_busy(int'(read_addr_1_i))));
      chk("rand busy_2", 32'(busy_2_o), 32'(model_busy(int'(read_addr_2_i))));
`ifdef WB_BYPASS_EN
      chk("rand fwd_1", 32'(fwd_1_o), 32'(m_we && m_wa == int'(read_addr_1_i)));
      chk("rand fwd_2", 32'(fwd_2_o), 32'(m_we && m_wa == int'(read_addr_2_i)));
      if (m_we) chk("rand fwd_data", fwd_data_o, m_wd);
`endif
      hold0 = bus.src0_valid_i && (g != 0);
      hold1 = bus.src1_valid_i && (g != 1);
      tick();
      chk_wport("rand", int'(m_we), m_wa, m_wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: src0 (execute/ALU) and src1 (load/CSR).
- Uses a registered output stage that drives the register file write port directly.
- Holds a per-register pending scoreboard: issue allocates a destination register, and the granted writeback clears it.
- Gives the decode stage busy flags for both source operands so it can stall on RAW hazards.

Parameters:
- DATA_W, `RISCV_WORD_WIDTH (32): write data width.
- REG_COUNT, `GP_REG_COUNT (32): number of architectural registers.
- ADDR_W, $clog2(REG_COUNT) (5): register address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- src0_valid_i  in  1  execute writeback request.
- src0_ready_o  out  1  execute writeback accepted this cycle.
- src0_addr_i  in  ADDR_W  execute destination register.
- src0_data_i  in  DATA_W  execute result.
- src1_valid_i / src1_ready_o / src1_addr_i / src1_data_i: same as src0, for load/CSR writeback.
- alloc_i  in  1  issue marks a destination pending.
- alloc_addr_i  in  ADDR_W  register being allocated.
- flush_i  in  1  pipeline flush.
- read_addr_1_i, read_addr_2_i  in  ADDR_W  decode operand addresses.
- busy_1_o, busy_2_o  out  1  operand not yet readable from the register file.
- write_en_o  out  1  register file write enable.
- write_addr_o  out  ADDR_W  register file write address.
- write_data_o  out  DATA_W  register file write data.

Behaviour:
- Reset: write_en_o=0, write_addr_o=0, write_data_o=0, all pending bits=0, rr_ptr=0. Reset is asynchronous and takes effect mid-operation; any in-flight write is lost.
- Handshake:
  - A transfer occurs when valid_i && ready_o.
  - A source with valid_i=1 and ready_o=0 must hold valid_i, addr_i and data_i stable.
  - ready_o is combinational from the valid inputs, rr_ptr and flush_i.
- Grant:
  - Only one source valid: that source is granted.
  - Both valid: grant src[rr_ptr]; the other source waits exactly one cycle.
  - rr_ptr toggles only on a cycle where both sources are valid and one is granted.
  - At most one grant per cycle.
- Output stage:
  - On a granted transfer: write_en_o <= (addr != 0), write_addr_o <= addr, write_data_o <= data.
  - With no transfer: write_en_o <= 0; addr/data hold their last values.
  - Latency from handshake to register file update is 2 edges.
- x0:
  - Writes to x0 complete the handshake but never assert write_en_o.
  - alloc of x0 is ignored.
  - busy is always 0 for x0.
- Scoreboard:
  - alloc_i sets pending[alloc_addr_i].
  - A granted transfer clears pending[addr].
  - Same register set and cleared on the same edge: set wins (newer producer).
- Busy:
  - busy_n_o = pending[a] | (write_en_o && write_addr_o==a), for a != 0.
  - Fully combinational.
- flush_i:
  - Synchronously clears all pending bits and forces both ready_o=0 that cycle.
  - A write already in the output stage still commits.
  - alloc_i is ignored on the flush cycle.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs fwd_1_o and fwd_2_o (1 bit each) and fwd_data_o (DATA_W).
  - When write_en_o && write_addr_o == read_addr_n_i: fwd_n_o=1 and fwd_data_o=write_data_o.
  - In that case busy_n_o does not include the in-flight term; it reduces to pending[a].
- Undefined:
  - No fwd ports.
  - busy includes the in-flight term, so decode stalls one extra cycle.

Decomposition:
- Package wb_pkg holds:
  - typedef reg_addr_t (ADDR_W);
  - typedef word_t (DATA_W);
  - enum src_id_e {SRC_EXEC, SRC_LOAD};
  - localparam REG_ZERO = 0.
- Sub-module reg_scoreboard: pending vector with alloc/clear/flush and two combinational busy lookups. The arbiter and output stage stay in wb_arbiter.

Test Plan:
- Only src0 valid, addr 5, data 0xDEAD_BEEF:
  - src0_ready_o=1 on the same cycle;
  - next cycle write_en_o=1, write_addr_o=5, write_data_o=0xDEADBEEF;
  - the cycle after that, write_en_o=0.
- After reset, both valid (src0 addr 3, src1 addr 4) held 2 cycles:
  - cycle 0 grants src0;
  - cycle 1 grants src1;
  - write port shows 3 then 4;
  - rr_ptr returns to 0.
- alloc addr 7, then src1 writes 7:
  - busy_1_o (read_addr_1_i=7) is 1 until the grant edge;
  - without bypass, busy stays 1 one more cycle, then 0;
  - with WB_BYPASS_EN, busy=0 and fwd_1_o=1 with the data during the in-flight cycle.
- alloc_i on addr 9 on the same edge as a granted write to 9: pending[9]=1 afterwards.
- src0 writes x0 with data 0x1234: ready=1, write_en_o stays 0; alloc of 0 leaves busy=0.
- Sequence:
  - cycle A: alloc 10, 11;
  - cycle B: flush_i=1 with src0 valid to 12;
  - cycle C: rst asserted mid-cycle.
  Required response:
  - cycle B: ready=0 and pending cleared;
  - cycle C: all outputs 0 immediately, without a clock edge.
